// File: rtl/rgb_fade_pwm.sv
`timescale 1ns / 1ps
// rgb_fade_pwm: three-channel RGB PWM driver with linear crossfade toward on/off levels.
// Duty changes are double-buffered: a shadow duty ramps, and the active duty only picks it
// up at the end of a PWM period so pulses are never cut short or stretched.
// Build option: define RGB_FADE_EN to enable ramping; otherwise the shadow duty follows the
// requested level directly and colour changes snap at the next period boundary.
module rgb_fade_pwm #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 3900
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic red_pwm,
  output logic green_pwm,
  output logic blue_pwm,
  output logic settled
);

  localparam logic [PWM_BITS-1:0] MaxDuty = '1;

  // Channel index order: 0 = red, 1 = green, 2 = blue.
  logic [2:0]          lvl;
  logic [PWM_BITS-1:0] tgt     [3];
  logic [PWM_BITS-1:0] shd_q   [3];
  logic [PWM_BITS-1:0] shd_d   [3];
  logic [PWM_BITS-1:0] act_q   [3];
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                period_end;
  logic [2:0]          pwm_q;
  logic [2:0]          pwm_d;
  logic                settled_q;
  logic                settled_d;

  assign lvl        = {blue_in, green_in, red_in};
  assign period_end = (pwm_cnt_q == MaxDuty);

  // Targets are full-on or full-off per requested level, re-evaluated every cycle.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      tgt[c] = lvl[c] ? MaxDuty : '0;
    end
  end

`ifdef RGB_FADE_EN
  localparam int unsigned    StepW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);

  logic [StepW-1:0] step_cnt_q;
  logic             tick;

  assign tick = (step_cnt_q == StepLast);

  // Step timer: wraps every STEP_CYCLES cycles, tick marks the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
    end else if (tick) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_q + 1'b1;
    end
  end

  // Shadow duty moves one LSB toward the target per tick; equality holds, so no overshoot.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      shd_d[c] = shd_q[c];
      if (tick) begin
        if (shd_q[c] < tgt[c]) begin
          shd_d[c] = shd_q[c] + 1'b1;
        end else if (shd_q[c] > tgt[c]) begin
          shd_d[c] = shd_q[c] - 1'b1;
        end
      end
    end
  end
`else
  // Without fading the shadow duty tracks the target directly.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      shd_d[c] = tgt[c];
    end
  end
`endif

  // Shadow duty registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) shd_q[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) shd_q[c] <= shd_d[c];
    end
  end

  // Free-running PWM counter; wraps naturally at MaxDuty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  // Active duty samples the registered (pre-tick) shadow value at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) act_q[c] <= '0;
    end else if (period_end) begin
      for (int c = 0; c < 3; c++) act_q[c] <= shd_q[c];
    end
  end

  // PWM compare and settled detection, both registered on the next edge.
  always_comb begin
    settled_d = 1'b1;
    for (int c = 0; c < 3; c++) begin
      pwm_d[c] = (act_q[c] == MaxDuty) || (pwm_cnt_q < act_q[c]);
      if (act_q[c] != tgt[c]) settled_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q     <= '0;
      settled_q <= 1'b0;
    end else begin
      pwm_q     <= pwm_d;
      settled_q <= settled_d;
    end
  end

  assign red_pwm   = pwm_q[0];
  assign green_pwm = pwm_q[1];
  assign blue_pwm  = pwm_q[2];
  assign settled   = settled_q;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
`timescale 1ns / 1ps
// Directed testbench for rgb_fade_pwm with PWM_BITS=4 (16-cycle period) and STEP_CYCLES=4.
// Cycle k counts posedges after reset release; outputs are sampled on the following negedge.
module tb_rgb_fade_pwm;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic red_in   = 1'b0;
  logic green_in = 1'b0;
  logic blue_in  = 1'b0;
  logic red_pwm;
  logic green_pwm;
  logic blue_pwm;
  logic settled;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  logic r_h [256];
  logic g_h [256];
  logic b_h [256];
  logic s_h [256];

  always #5 clk = ~clk;

  rgb_fade_pwm #(
    .PWM_BITS    (4),
    .STEP_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .red_pwm   (red_pwm),
    .green_pwm (green_pwm),
    .blue_pwm  (blue_pwm),
    .settled   (settled)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock and record outputs for cycle k.
  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
    k = k + 1;
    if (k < 256) begin
      r_h[k] = red_pwm;
      g_h[k] = green_pwm;
      b_h[k] = blue_pwm;
      s_h[k] = settled;
    end
  endtask

  // High cycles of channel ch (0 r, 1 g, 2 b) in period m = cycles 16m+1 .. 16m+16.
  function automatic int count(input int ch, input int m);
    int n = 0;
    for (int i = 16 * m + 1; i <= 16 * m + 16; i++) begin
      if (ch == 0 && r_h[i] === 1'b1) n++;
      if (ch == 1 && g_h[i] === 1'b1) n++;
      if (ch == 2 && b_h[i] === 1'b1) n++;
    end
    return n;
  endfunction

  // Reset with given inputs, release at a negedge so the next posedge is cycle 1.
  task automatic do_reset(input logic r, input logic g, input logic b);
    @(negedge clk);
    rst_n    = 1'b0;
    red_in   = r;
    green_in = g;
    blue_in  = b;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      r_h[i] = 1'b0;
      g_h[i] = 1'b0;
      b_h[i] = 1'b0;
      s_h[i] = 1'b0;
    end
    k     = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_s;
`ifdef RGB_FADE_EN
    exp_s = 1'b0;
`else
    exp_s = 1'b1;
`endif
    @(negedge clk);
    rst_n    = 1'b0;
    red_in   = 1'b1;
    green_in = 1'b1;
    blue_in  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({red_pwm, green_pwm, blue_pwm, settled} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected 0000", i,
                 {red_pwm, green_pwm, blue_pwm, settled});
      end
    end
    k     = 0;
    rst_n = 1'b1;
    repeat (34) step_cycle();
    checks++;
    if ({red_pwm, green_pwm, blue_pwm, settled} !== {3'b111, exp_s}) begin
      errors++;
      $display("FAIL reset_midramp_outputs: got %b expected %b",
               {red_pwm, green_pwm, blue_pwm, settled}, {3'b111, exp_s});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({red_pwm, green_pwm, blue_pwm, settled} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async_assert: got %b expected 0000",
               {red_pwm, green_pwm, blue_pwm, settled});
    end
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (16) step_cycle();
    checks++;
    if (count(0, 0) + count(1, 0) + count(2, 0) !== 0) begin
      errors++;
      $display("FAIL reset_restart_from_zero: got %0d high cycles expected 0",
               count(0, 0) + count(1, 0) + count(2, 0));
    end
  endtask

`ifdef RGB_FADE_EN
  task automatic test_ramp_up();
    int exp_r [5];
    exp_r = '{0, 3, 7, 11, 16};
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (80) step_cycle();
    for (int m = 0; m < 5; m++) begin
      checks++;
      if (count(0, m) !== exp_r[m]) begin
        errors++;
        $display("FAIL ramp_up_red period %0d: got %0d expected %0d", m, count(0, m), exp_r[m]);
      end
    end
    checks++;
    if (count(1, 2) + count(2, 2) + count(1, 4) + count(2, 4) !== 0) begin
      errors++;
      $display("FAIL ramp_up_gb_idle: got %0d expected 0",
               count(1, 2) + count(2, 2) + count(1, 4) + count(2, 4));
    end
    checks++;
    if ({s_h[64], s_h[65], s_h[80]} !== 3'b011) begin
      errors++;
      $display("FAIL ramp_up_settled: got %b expected 011", {s_h[64], s_h[65], s_h[80]});
    end
  endtask

  task automatic test_coincidence();
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (32) step_cycle();
    checks++;
    if (count(0, 1) !== 3) begin
      errors++;
      $display("FAIL coincidence_pre_tick_duty: got %0d expected 3", count(0, 1));
    end
    checks++;
    if ({r_h[16], r_h[17], r_h[18], r_h[19], r_h[20]} !== 5'b01110) begin
      errors++;
      $display("FAIL coincidence_pulse_shape: got %b expected 01110",
               {r_h[16], r_h[17], r_h[18], r_h[19], r_h[20]});
    end
  endtask

  task automatic test_reversal();
    int exp_r [6];
    exp_r = '{0, 3, 7, 7, 3, 0};
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 96; i++) begin
      step_cycle();
      if (k == 38) red_in = 1'b0;
    end
    for (int m = 0; m < 6; m++) begin
      checks++;
      if (count(0, m) !== exp_r[m]) begin
        errors++;
        $display("FAIL reversal_red period %0d: got %0d expected %0d", m, count(0, m), exp_r[m]);
      end
    end
    checks++;
    if ({s_h[80], s_h[81], s_h[96]} !== 3'b011) begin
      errors++;
      $display("FAIL reversal_settled: got %b expected 011", {s_h[80], s_h[81], s_h[96]});
    end
  endtask

  task automatic test_three_channels();
    int exp_r [12];
    int exp_g [12];
    exp_r = '{0, 3, 7, 11, 16, 16, 16, 13, 9, 5, 1, 0};
    exp_g = '{0, 0, 0, 0, 0, 2, 6, 10, 14, 16, 16, 16};
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 192; i++) begin
      step_cycle();
      if (k == 70) green_in = 1'b1;
      if (k == 100) red_in = 1'b0;
    end
    for (int m = 0; m < 12; m++) begin
      checks++;
      if (count(0, m) !== exp_r[m] || count(1, m) !== exp_g[m] || count(2, m) !== 0) begin
        errors++;
        $display("FAIL three_ch period %0d: got r%0d g%0d b%0d expected r%0d g%0d b0", m,
                 count(0, m), count(1, m), count(2, m), exp_r[m], exp_g[m]);
      end
    end
    checks++;
    if ({s_h[65], s_h[70], s_h[71], s_h[145], s_h[176], s_h[177], s_h[192]} !== 7'b1100011) begin
      errors++;
      $display("FAIL three_ch_settled: got %b expected 1100011",
               {s_h[65], s_h[70], s_h[71], s_h[145], s_h[176], s_h[177], s_h[192]});
    end
  endtask
`else
  task automatic test_fade_disabled();
    int exp_r [3];
    int exp_b [3];
    exp_r = '{0, 0, 16};
    exp_b = '{0, 16, 0};
    do_reset(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      step_cycle();
      if (k == 20) begin
        blue_in = 1'b0;
        red_in  = 1'b1;
      end
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (count(0, m) !== exp_r[m]) begin
        errors++;
        $display("FAIL snap_red period %0d: got %0d expected %0d", m, count(0, m), exp_r[m]);
      end
      checks++;
      if (count(2, m) !== exp_b[m]) begin
        errors++;
        $display("FAIL snap_blue period %0d: got %0d expected %0d", m, count(2, m), exp_b[m]);
      end
      checks++;
      if (count(1, m) !== 0) begin
        errors++;
        $display("FAIL snap_green period %0d: got %0d expected 0", m, count(1, m));
      end
    end
    checks++;
    if ({b_h[16], b_h[17]} !== 2'b01) begin
      errors++;
      $display("FAIL snap_blue_edge: got %b expected 01", {b_h[16], b_h[17]});
    end
    checks++;
    if ({s_h[16], s_h[17], s_h[20], s_h[21], s_h[32], s_h[33], s_h[48]} !== 7'b0110011) begin
      errors++;
      $display("FAIL snap_settled: got %b expected 0110011",
               {s_h[16], s_h[17], s_h[20], s_h[21], s_h[32], s_h[33], s_h[48]});
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef RGB_FADE_EN
    test_ramp_up();
    test_coincidence();
    test_reversal();
    test_three_channels();
`else
    test_fade_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
